// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci LFSR for AHB VIP stimulus.
// Optional macro LFSR_WRAP_DET_EN enables start-value wrap detection.
module lfsr_gen #(
    parameter int              WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS = 16'hB400,
    parameter logic [WIDTH-1:0] SEED = 16'h0001,
    parameter int              STEPS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] random_data,
    output logic             upd,
    output logic             zero_fix,
    output logic             wrap
);

    logic [WIDTH-1:0] r_state;
    logic             r_upd;
    logic             r_zfix;
    logic             r_wrap;

    logic [WIDTH-1:0] w_adv;
    logic             w_adv_zero;
    logic [WIDTH-1:0] w_adv_fix;
    logic             w_load_zero;
    logic [WIDTH-1:0] w_load_fix;

    // One Fibonacci shift: parity of tapped bits enters at bit 0
    function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] s);
        logic fb;
        fb = ^(s & TAPS);
        return {s[WIDTH-2:0], fb};
    endfunction

    // Chain STEPS single shifts within one clock
    always_comb begin
        w_adv = r_state;
        for (int k = 0; k < STEPS; k++) begin
            w_adv = f_step(w_adv);
        end
    end

    // Zero-lock recovery for both the advance and the reseed paths
    always_comb begin
        w_adv_zero  = (w_adv == '0);
        w_adv_fix   = w_adv_zero ? SEED : w_adv;
        w_load_zero = (load_val == '0);
        w_load_fix  = w_load_zero ? SEED : load_val;
    end

`ifdef LFSR_WRAP_DET_EN
    logic [WIDTH-1:0] r_start;

    // Track the value the current sequence started from and flag returns to it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_start <= SEED;
            r_wrap  <= 1'b0;
        end else if (load) begin
            r_start <= w_load_fix;
            r_wrap  <= 1'b0;
        end else if (en) begin
            if (w_adv_zero) begin
                r_start <= SEED;
            end
            r_wrap <= (w_adv_fix == r_start);
        end else begin
            r_wrap <= 1'b0;
        end
    end
`else
    // Wrap detection absent: pulse is held low
    always_ff @(posedge clk) begin
        r_wrap <= 1'b0;
    end
`endif

    // State update and registered pulses; reset > load > en > hold
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SEED;
            r_upd   <= 1'b0;
            r_zfix  <= 1'b0;
        end else if (load) begin
            r_state <= w_load_fix;
            r_upd   <= 1'b1;
            r_zfix  <= w_load_zero;
        end else if (en) begin
            r_state <= w_adv_fix;
            r_upd   <= 1'b1;
            r_zfix  <= w_adv_zero;
        end else begin
            r_upd   <= 1'b0;
            r_zfix  <= 1'b0;
        end
    end

    assign random_data = r_state;
    assign upd         = r_upd;
    assign zero_fix    = r_zfix;
    assign wrap        = r_wrap;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: directed and random checks of lfsr_gen against a
// sequence-level reference model (three configurations side by side).
module tb_lfsr_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;

    logic [3:0] rd[3];
    logic       upd[3];
    logic       zf[3];
    logic       wr[3];

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'b0001), .STEPS(1)) u_dut0 (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
        .random_data(rd[0]), .upd(upd[0]), .zero_fix(zf[0]), .wrap(wr[0])
    );

    lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'b0001), .STEPS(2)) u_dut2 (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
        .random_data(rd[1]), .upd(upd[1]), .zero_fix(zf[1]), .wrap(wr[1])
    );

    lfsr_gen #(.WIDTH(4), .TAPS(4'b0000), .SEED(4'b0001), .STEPS(1)) u_dut3 (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
        .random_data(rd[2]), .upd(upd[2]), .zero_fix(zf[2]), .wrap(wr[2])
    );

    // Reference model state per instance
    logic [3:0] m_taps[3] = '{4'b1100, 4'b1100, 4'b0000};
    int         m_steps[3] = '{1, 2, 1};
    logic [3:0] m_s[3];
    logic [3:0] m_start[3];
    logic       m_upd[3];
    logic       m_zf[3];
    logic       m_wrap[3];
    logic       m_enfix[3];

    logic [3:0] seq15[15] = '{4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110,
                              4'b1101, 4'b1010, 4'b0101, 4'b1011, 4'b0111,
                              4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Next state: shift left by one, drop the top bit, append tap parity
    function automatic logic [3:0] m_next(input logic [3:0] s, input logic [3:0] t);
        int v;
        v = (int'(s) * 2) % 16 + ($countones(s & t) % 2);
        return 4'(v);
    endfunction

    task automatic model_edge();
        logic [3:0] a;
        for (int i = 0; i < 3; i++) begin
            m_enfix[i] = 1'b0;
            if (reset) begin
                m_s[i] = 4'b0001;
                m_start[i] = 4'b0001;
                m_upd[i] = 1'b0;
                m_zf[i] = 1'b0;
                m_wrap[i] = 1'b0;
            end else if (load) begin
                m_s[i] = (load_val == 4'd0) ? 4'b0001 : load_val;
                m_start[i] = m_s[i];
                m_upd[i] = 1'b1;
                m_zf[i] = (load_val == 4'd0);
                m_wrap[i] = 1'b0;
            end else if (en) begin
                a = m_s[i];
                for (int k = 0; k < m_steps[i]; k++) a = m_next(a, m_taps[i]);
                m_zf[i] = (a == 4'd0);
                m_enfix[i] = m_zf[i];
                if (m_zf[i]) a = 4'b0001;
`ifdef LFSR_WRAP_DET_EN
                m_wrap[i] = (a == m_start[i]);
`else
                m_wrap[i] = 1'b0;
`endif
                if (m_zf[i]) m_start[i] = 4'b0001;
                m_s[i] = a;
                m_upd[i] = 1'b1;
            end else begin
                m_upd[i] = 1'b0;
                m_zf[i] = 1'b0;
                m_wrap[i] = 1'b0;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("d%0d_rd", i), 32'(rd[i]), 32'(m_s[i]));
            chk($sformatf("d%0d_upd", i), 32'(upd[i]), 32'(m_upd[i]));
            chk($sformatf("d%0d_zf", i), 32'(zf[i]), 32'(m_zf[i]));
            if (!m_enfix[i]) chk($sformatf("d%0d_wrap", i), 32'(wr[i]), 32'(m_wrap[i]));
        end
    endtask

    initial begin
        logic wexp;
        for (int i = 0; i < 3; i++) begin
            m_s[i] = 4'd0; m_start[i] = 4'd0;
            m_upd[i] = 1'b0; m_zf[i] = 1'b0; m_wrap[i] = 1'b0; m_enfix[i] = 1'b0;
        end

        // Reset state
        reset = 1'b1;
        step();
        chk("rst_rd", 32'(rd[0]), 32'h1);
        chk("rst_upd", 32'(upd[0]), 32'h0);
        chk("rst_zf", 32'(zf[0]), 32'h0);
        chk("rst_wrap", 32'(wr[0]), 32'h0);
        reset = 1'b0;

        // Full period, plus multi-step and degenerate-tap sequences
        en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            chk($sformatf("seq%0d", i), 32'(rd[0]), 32'(seq15[i]));
            chk($sformatf("seq_upd%0d", i), 32'(upd[0]), 32'h1);
`ifdef LFSR_WRAP_DET_EN
            wexp = (i == 14);
`else
            wexp = 1'b0;
`endif
            chk($sformatf("seq_wrap%0d", i), 32'(wr[0]), 32'(wexp));
            if (i == 0) chk("ms0", 32'(rd[1]), 32'b0100);
            if (i == 1) chk("ms1", 32'(rd[1]), 32'b0011);
            if (i == 0) chk("dg0", 32'(rd[2]), 32'b0010);
            if (i == 1) chk("dg1", 32'(rd[2]), 32'b0100);
            if (i == 2) chk("dg2", 32'(rd[2]), 32'b1000);
            if (i == 3) chk("dg3", 32'(rd[2]), 32'b0001);
            if (i == 3) chk("dg3_zf", 32'(zf[2]), 32'h1);
            if (i == 4) chk("dg4_zf", 32'(zf[2]), 32'h0);
        end

        // Hold
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_rd", 32'(rd[0]), 32'h1);
            chk("hold_upd", 32'(upd[0]), 32'h0);
        end

        // Reseed with en asserted: no step on top of the load
        load = 1'b1; en = 1'b1; load_val = 4'b1010;
        step();
        chk("ld_rd", 32'(rd[0]), 32'b1010);
        chk("ld_upd", 32'(upd[0]), 32'h1);
        chk("ld_wrap", 32'(wr[0]), 32'h0);
        load = 1'b0;
        step();
        chk("ld_next", 32'(rd[0]), 32'b0101);

        // Zero reseed recovers to SEED
        load = 1'b1; en = 1'b0; load_val = 4'b0000;
        step();
        chk("z_rd", 32'(rd[0]), 32'h1);
        chk("z_zf", 32'(zf[0]), 32'h1);
        chk("z_upd", 32'(upd[0]), 32'h1);
        load = 1'b0; en = 1'b1;
        step();
        chk("z_next", 32'(rd[0]), 32'b0010);
        chk("z_zf_clr", 32'(zf[0]), 32'h0);

        // Reset mid-run wins over load and en
        reset = 1'b1; en = 1'b0;
        step();
        reset = 1'b0; en = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("mid_pre", 32'(rd[0]), 32'b1101);
        reset = 1'b1; load = 1'b1; load_val = 4'b0111;
        step();
        chk("mid_rd", 32'(rd[0]), 32'h1);
        chk("mid_upd", 32'(upd[0]), 32'h0);
        chk("mid_zf", 32'(zf[0]), 32'h0);
        chk("mid_wrap", 32'(wr[0]), 32'h0);
        reset = 1'b0; load = 1'b0;

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom % 60) == 0;
            load = ($urandom % 14) == 0;
            en = ($urandom % 4) != 0;
            load_val = 4'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
